// File: rtl/rabbit_pkg.sv
// Shared definitions for the Rabbit keystream core: counter constants,
// controller state encoding and the 32-bit rotate helper.
package rabbit_pkg;

  // Counter increments A7..A0 (index 0 is the rightmost element)
  localparam logic [7:0][31:0] A_CONST = {
    32'hD34D34D3, 32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3,
    32'h4D34D34D, 32'h34D34D34, 32'hD34D34D3, 32'h4D34D34D
  };

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    FIXUP,
    GEN,
    OUT
  } state_e;

  // 32-bit left rotate by n positions
  function automatic logic [31:0] rotl32(input logic [31:0] v, input int unsigned n);
    rotl32 = (v << n) | (v >> (32 - n));
  endfunction

endpackage

// File: rtl/G_function.sv
// Rabbit g-function: square the 32-bit sum of state and counter and fold
// the high and low halves of the 64-bit product together with XOR.
module G_function (
  input  logic [31:0] counter,
  input  logic [31:0] state,
  output logic [31:0] g_out
);

  logic [31:0] sum;
  logic [63:0] square;

  // Full 64-bit square of (state + counter mod 2^32), then fold
  always_comb begin
    sum    = state + counter;
    square = {32'h0, sum} * {32'h0, sum};
    g_out  = square[63:32] ^ square[31:0];
  end

endmodule

// File: rtl/rabbit_keystream_core.sv
// Rabbit keystream generator: loads a 128-bit key, runs key setup and the
// counter fix-up, then streams one 128-bit keystream block per accepted
// handshake over a valid/ready interface.
module rabbit_keystream_core
  import rabbit_pkg::*;
#(
  parameter int SETUP_ITERS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         ks_valid,
  input  logic         ks_ready,
  output logic [127:0] ks_data,
  output logic         busy
);

  localparam logic [7:0] LAST_ITER = 8'(SETUP_ITERS - 1);

  state_e            state_q, state_d;
  logic [7:0][31:0]  x_q, x_d;
  logic [7:0][31:0]  c_q, c_d;
  logic              phi_q, phi_d;
  logic [7:0]        iter_q, iter_d;

  logic [7:0][15:0]  k_w;
  logic [7:0][31:0]  x_load, c_load;
  logic [7:0][31:0]  c_step, x_step, g_val;
  logic              phi_step;
  logic              carry;
  logic [32:0]       csum;
  logic [127:0]      extract;

  assign k_w = key;

  // Key expansion into initial state and counter words
  always_comb begin
    x_load[0] = {k_w[1], k_w[0]};
    x_load[1] = {k_w[6], k_w[5]};
    x_load[2] = {k_w[3], k_w[2]};
    x_load[3] = {k_w[0], k_w[7]};
    x_load[4] = {k_w[5], k_w[4]};
    x_load[5] = {k_w[2], k_w[1]};
    x_load[6] = {k_w[7], k_w[6]};
    x_load[7] = {k_w[4], k_w[3]};
    c_load[0] = {k_w[4], k_w[5]};
    c_load[1] = {k_w[1], k_w[2]};
    c_load[2] = {k_w[6], k_w[7]};
    c_load[3] = {k_w[3], k_w[4]};
    c_load[4] = {k_w[0], k_w[1]};
    c_load[5] = {k_w[5], k_w[6]};
    c_load[6] = {k_w[2], k_w[3]};
    c_load[7] = {k_w[7], k_w[0]};
  end

  // Counter update: one carry chain through all eight words in a cycle
  always_comb begin
    carry  = phi_q;
    csum   = '0;
    c_step = '0;
    for (int j = 0; j < 8; j++) begin
      csum      = {1'b0, c_q[j]} + {1'b0, A_CONST[j]} + {32'h0, carry};
      c_step[j] = csum[31:0];
      carry     = csum[32];
    end
    phi_step = carry;
  end

  // Eight parallel g-functions fed by the freshly updated counters
  for (genvar gi = 0; gi < 8; gi++) begin : g_gfunc
    G_function u_g (
      .counter (c_step[gi]),
      .state   (x_q[gi]),
      .g_out   (g_val[gi])
    );
  end

  // Next-state mixing of the g values
  always_comb begin
    x_step[0] = g_val[0] + rotl32(g_val[7], 16) + rotl32(g_val[6], 16);
    x_step[1] = g_val[1] + rotl32(g_val[0], 8)  + g_val[7];
    x_step[2] = g_val[2] + rotl32(g_val[1], 16) + rotl32(g_val[0], 16);
    x_step[3] = g_val[3] + rotl32(g_val[2], 8)  + g_val[1];
    x_step[4] = g_val[4] + rotl32(g_val[3], 16) + rotl32(g_val[2], 16);
    x_step[5] = g_val[5] + rotl32(g_val[4], 8)  + g_val[3];
    x_step[6] = g_val[6] + rotl32(g_val[5], 16) + rotl32(g_val[4], 16);
    x_step[7] = g_val[7] + rotl32(g_val[6], 8)  + g_val[5];
  end

  // Controller: decides when the shared step, load or fix-up is registered
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    c_d     = c_q;
    phi_d   = phi_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (key_valid) begin
          x_d     = x_load;
          c_d     = c_load;
          phi_d   = 1'b0;
          iter_d  = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        x_d    = x_step;
        c_d    = c_step;
        phi_d  = phi_step;
        iter_d = iter_q + 8'd1;
        if (iter_q == LAST_ITER) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        c_d     = c_q ^ {x_q[3:0], x_q[7:4]};
        state_d = GEN;
      end
      GEN: begin
        x_d     = x_step;
        c_d     = c_step;
        phi_d   = phi_step;
        state_d = OUT;
      end
      OUT: begin
        if (ks_ready) begin
          x_d   = x_step;
          c_d   = c_step;
          phi_d = phi_step;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      x_d     = '0;
      c_d     = '0;
      phi_d   = 1'b0;
      iter_d  = '0;
    end
  end

  // State, counter and carry registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      c_q     <= '0;
      phi_q   <= 1'b0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      c_q     <= c_d;
      phi_q   <= phi_d;
      iter_q  <= iter_d;
    end
  end

  // Keystream extraction from the registered state words
  always_comb begin
    extract[15:0]    = x_q[0][15:0]  ^ x_q[5][31:16];
    extract[31:16]   = x_q[0][31:16] ^ x_q[3][15:0];
    extract[47:32]   = x_q[2][15:0]  ^ x_q[7][31:16];
    extract[63:48]   = x_q[2][31:16] ^ x_q[5][15:0];
    extract[79:64]   = x_q[4][15:0]  ^ x_q[1][31:16];
    extract[95:80]   = x_q[4][31:16] ^ x_q[7][15:0];
    extract[111:96]  = x_q[6][15:0]  ^ x_q[3][31:16];
    extract[127:112] = x_q[6][31:16] ^ x_q[1][15:0];
  end

  // Handshake and status outputs; keystream is masked when not valid
  always_comb begin
    key_ready = (state_q == IDLE) && !clear;
    ks_valid  = (state_q == OUT);
    busy      = (state_q == SETUP) || (state_q == FIXUP) || (state_q == GEN);
    ks_data   = ks_valid ? extract : '0;
  end

endmodule
